// File: rtl/decode_pkg.sv
// Shared types and constants for the decode queue: field-select encodings,
// the link-register index and the stored entry width.
package decode_pkg;

  typedef enum logic [1:0] {
    SEL_RT = 2'b00,
    SEL_RD = 2'b01,
    SEL_RA = 2'b10,
    SEL_R0 = 2'b11
  } regdest_sel_e;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_LUI  = 2'b10,
    IMM_ZERO = 2'b11
  } immmode_e;

  localparam logic [4:0] REG_RA = 5'd31;

  // Entry is {bundle, regdest[5], imedext[32], nextpc[32]}.
  function automatic int entry_w(input int ctrl_w);
    return ctrl_w + 69;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH in-order storage with wrapping pointers, occupancy
// count and a synchronous flush; head data reads zero while empty.
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_data,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/decode_queue.sv
// Decode stage: extracts destination register and extended immediate, then
// queues entries for Issue. Optional same-cycle bypass: DECODE_QUEUE_BYPASS_EN.
import decode_pkg::*;

module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int CTRL_W = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         if_id_valid,
  output logic                         id_if_ready,
  input  logic [31:0]                  if_id_instruc,
  input  logic [31:0]                  if_id_nextpc,
  input  logic [CTRL_W-1:0]            ctl_id_bundle,
  input  logic [1:0]                   ctl_id_selregdest,
  input  logic [1:0]                   ctl_id_immmode,
  input  logic                         flush,
  output logic                         id_is_valid,
  input  logic                         is_id_ready,
  output logic [CTRL_W-1:0]            id_is_bundle,
  output logic [4:0]                   id_is_regdest,
  output logic [31:0]                  id_is_imedext,
  output logic [31:0]                  id_is_nextpc,
  output logic [$clog2(DEPTH+1)-1:0]   id_is_count
);

  localparam int EW = entry_w(CTRL_W);
  localparam int CW = $clog2(DEPTH+1);

  logic [4:0]         w_regdest;
  logic [31:0]        w_imedext;
  logic signed [15:0] w_imm_s;
  logic [EW-1:0]      w_entry;
  logic [EW-1:0]      w_fifo_head;
  logic [EW-1:0]      w_head;
  logic [CW-1:0]      w_count;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_unused;

  assign w_imm_s  = signed'(if_id_instruc[15:0]);
  assign w_unused = ^if_id_instruc[31:21];

  always_comb begin
    w_regdest = '0;
    case (regdest_sel_e'(ctl_id_selregdest))
      SEL_RT: w_regdest = if_id_instruc[20:16];
      SEL_RD: w_regdest = if_id_instruc[15:11];
      SEL_RA: w_regdest = REG_RA;
      SEL_R0: w_regdest = '0;
    endcase
    w_imedext = '0;
    case (immmode_e'(ctl_id_immmode))
      IMM_SEXT: w_imedext = 32'(w_imm_s);
      IMM_ZEXT: w_imedext = {16'b0, if_id_instruc[15:0]};
      IMM_LUI:  w_imedext = {if_id_instruc[15:0], 16'b0};
      IMM_ZERO: w_imedext = '0;
    endcase
  end

  assign w_entry = {ctl_id_bundle, w_regdest, w_imedext, if_id_nextpc};

  // Ready looks only at stored occupancy, keeping Issue off the Fetch path.
  assign w_empty     = (w_count == '0);
  assign id_if_ready = (w_count < CW'(DEPTH));
  assign w_pop       = !w_empty && is_id_ready && !flush;

`ifdef DECODE_QUEUE_BYPASS_EN
  logic w_byp_take;
  assign w_byp_take  = w_empty && if_id_valid && is_id_ready && !flush;
  assign w_push      = if_id_valid && id_if_ready && !flush && !w_byp_take;
  assign id_is_valid = !w_empty || (if_id_valid && !flush);
  assign w_head      = !w_empty ? w_fifo_head :
                       (if_id_valid && !flush) ? w_entry : '0;
`else
  assign w_push      = if_id_valid && id_if_ready && !flush;
  assign id_is_valid = !w_empty;
  assign w_head      = w_fifo_head;
`endif

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_data  (w_fifo_head),
    .o_count (w_count)
  );

  assign {id_is_bundle, id_is_regdest, id_is_imedext, id_is_nextpc} = w_head;
  assign id_is_count = w_count;

endmodule

// File: tb/tb_decode_queue.sv
// Randomised and directed bench for decode_queue with a queue-based
// reference model and an independent monitor comparing the head each cycle.
module tb_decode_queue;

  localparam int DEPTH  = 4;
  localparam int CTRL_W = 20;

  typedef struct packed {
    logic [CTRL_W-1:0] b;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [31:0]       pc;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_id_valid;
  logic              id_if_ready;
  logic [31:0]       if_id_instruc;
  logic [31:0]       if_id_nextpc;
  logic [CTRL_W-1:0] ctl_id_bundle;
  logic [1:0]        ctl_id_selregdest;
  logic [1:0]        ctl_id_immmode;
  logic              flush;
  logic              id_is_valid;
  logic              is_id_ready;
  logic [CTRL_W-1:0] id_is_bundle;
  logic [4:0]        id_is_regdest;
  logic [31:0]       id_is_imedext;
  logic [31:0]       id_is_nextpc;
  logic [2:0]        id_is_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q[$];
  logic head_empty = 1'b1;

  decode_queue #(.DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .if_id_valid       (if_id_valid),
    .id_if_ready       (id_if_ready),
    .if_id_instruc     (if_id_instruc),
    .if_id_nextpc      (if_id_nextpc),
    .ctl_id_bundle     (ctl_id_bundle),
    .ctl_id_selregdest (ctl_id_selregdest),
    .ctl_id_immmode    (ctl_id_immmode),
    .flush             (flush),
    .id_is_valid       (id_is_valid),
    .is_id_ready       (is_id_ready),
    .id_is_bundle      (id_is_bundle),
    .id_is_regdest     (id_is_regdest),
    .id_is_imedext     (id_is_imedext),
    .id_is_nextpc      (id_is_nextpc),
    .id_is_count       (id_is_count)
  );

  always #5 clock = ~clock;

  function automatic ent_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [CTRL_W-1:0] b, input logic [1:0] sel,
                                 input logic [1:0] md);
    ent_t e;
    int unsigned imm16;
    imm16 = ins & 32'hFFFF;
    e.b  = b;
    e.pc = pc;
    case (sel)
      2'd0: e.rd = 5'((ins >> 16) % 32);
      2'd1: e.rd = 5'((ins >> 11) % 32);
      2'd2: e.rd = 5'd31;
      default: e.rd = 5'd0;
    endcase
    case (md)
      2'd0: e.imm = (imm16 >= 32768) ? imm16 + 32'hFFFF0000 : imm16;
      2'd1: e.imm = imm16;
      2'd2: e.imm = imm16 * 65536;
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT head/flags against the model queue every cycle.
  always @(negedge clock) begin
    if (reset) begin
      int   sz;
      logic exp_v;
      ent_t exp_e;
      ent_t act;
      sz = exp_q.size();
      head_empty = (sz == 0);
      exp_v = (sz != 0);
      exp_e = (sz != 0) ? exp_q[0] : '0;
`ifdef DECODE_QUEUE_BYPASS_EN
      if (sz == 0 && if_id_valid && !flush) begin
        exp_v = 1'b1;
        exp_e = model(if_id_instruc, if_id_nextpc, ctl_id_bundle, ctl_id_selregdest, ctl_id_immmode);
      end
`endif
      act = {id_is_bundle, id_is_regdest, id_is_imedext, id_is_nextpc};
      n_tests++;
      if (int'(id_is_count) != sz) begin
        n_fail++;
        $display("FAIL mon_count t=%0t got %0d want %0d", $time, id_is_count, sz);
      end
      n_tests++;
      if (id_if_ready !== (sz < DEPTH)) begin
        n_fail++;
        $display("FAIL mon_ready t=%0t got %b want %b", $time, id_if_ready, (sz < DEPTH));
      end
      n_tests++;
      if (id_is_valid !== exp_v) begin
        n_fail++;
        $display("FAIL mon_valid t=%0t got %b want %b", $time, id_is_valid, exp_v);
      end
      n_tests++;
      if (act !== exp_e) begin
        n_fail++;
        $display("FAIL mon_head t=%0t got %h want %h", $time, act, exp_e);
      end
      if (sz != 0 && is_id_ready && !flush) void'(exp_q.pop_front());
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [CTRL_W-1:0] b, input logic [1:0] sel,
                     input logic [1:0] md, input logic fl, output logic acc);
    ent_t e;
    logic push_it;
    if_id_valid = v; if_id_instruc = ins; if_id_nextpc = pc;
    ctl_id_bundle = b; ctl_id_selregdest = sel; ctl_id_immmode = md; flush = fl;
    @(negedge clock); #1;
    acc = v && id_if_ready && !fl;
    push_it = acc;
`ifdef DECODE_QUEUE_BYPASS_EN
    if (acc && head_empty && is_id_ready) push_it = 1'b0;
`endif
    e = model(ins, pc, b, sel, md);
    @(posedge clock);
    if (fl) exp_q.delete();
    else if (push_it) exp_q.push_back(e);
    #1;
    if_id_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic [1:0] sel,
                       input logic [1:0] md);
    logic acc;
    logic [CTRL_W-1:0] b;
    b = CTRL_W'($urandom);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, ins, pc, b, sel, md, 1'b0, acc);
      if (acc) return;
    end
    chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cyc(1'b0, 32'd0, 32'd0, '0, 2'd0, 2'd0, 1'b0, acc);
  endtask

  logic [31:0] t_ins [4] = '{32'h2408FFFF, 32'h3508FFFF, 32'h3C081234, 32'h0C000010};
  logic [1:0]  t_sel [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
  logic [1:0]  t_md  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  logic [4:0]  t_rd  [4] = '{5'd8, 5'd8, 5'd8, 5'd31};
  logic [31:0] t_imm [4] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000, 32'h00000010};

  initial begin
    logic acc;
    reset = 1'b0; if_id_valid = 1'b0; is_id_ready = 1'b0; flush = 1'b0;
    if_id_instruc = '0; if_id_nextpc = '0; ctl_id_bundle = '0;
    ctl_id_selregdest = '0; ctl_id_immmode = '0;
    #2;
    chk("rst_count", 32'(id_is_count), 32'd0);
    chk("rst_valid", 32'(id_is_valid), 32'd0);
    chk("rst_ready", 32'(id_if_ready), 32'd1);
    chk("rst_imedext", id_is_imedext, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Field extraction, one entry at a time, checked one edge after enqueue.
    for (int i = 0; i < 4; i++) begin
      is_id_ready = 1'b0;
      cyc(1'b1, t_ins[i], 32'h1000 + 32'(i * 4), CTRL_W'($urandom), t_sel[i], t_md[i], 1'b0, acc);
      chk("fld_valid", 32'(id_is_valid), 32'd1);
      chk("fld_regdest", 32'(id_is_regdest), 32'(t_rd[i]));
      chk("fld_imedext", id_is_imedext, t_imm[i]);
      chk("fld_nextpc", id_is_nextpc, 32'h1000 + 32'(i * 4));
      is_id_ready = 1'b1;
      idle(1);
    end

    // Fill to full, hold the fifth, drain in order across the wrap.
    is_id_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) offer($urandom, 32'h2000 + 32'(i * 4), 2'(i), 2'(i));
      begin
        repeat (6) @(posedge clock);
        #2;
        chk("full_count", 32'(id_is_count), 32'd4);
        chk("full_ready", 32'(id_if_ready), 32'd0);
        is_id_ready = 1'b1;
      end
    join
    idle(DEPTH + 2);

    // Flush with count=3 and a simultaneous offer.
    is_id_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer($urandom, 32'h3000 + 32'(i * 4), 2'd1, 2'd0);
    cyc(1'b1, 32'hDEADBEEF, 32'h3FFC, '1, 2'd0, 2'd0, 1'b1, acc);
    chk("flush_count", 32'(id_is_count), 32'd0);
    chk("flush_valid", 32'(id_is_valid), 32'd0);
    is_id_ready = 1'b1;
    idle(3);

    // Empty queue, offer with Issue ready.
    is_id_ready = 1'b1;
    fork
      cyc(1'b1, 32'h2408FFFF, 32'h4004, CTRL_W'($urandom), 2'd0, 2'd0, 1'b0, acc);
      begin
        #2;
`ifdef DECODE_QUEUE_BYPASS_EN
        chk("empty_same_valid", 32'(id_is_valid), 32'd1);
`else
        chk("empty_same_valid", 32'(id_is_valid), 32'd0);
`endif
      end
    join
    is_id_ready = 1'b0;
    #1;
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("empty_next_count", 32'(id_is_count), 32'd0);
    chk("empty_next_valid", 32'(id_is_valid), 32'd0);
`else
    chk("empty_next_count", 32'(id_is_count), 32'd1);
    chk("empty_next_valid", 32'(id_is_valid), 32'd1);
`endif
    is_id_ready = 1'b1;
    idle(2);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      is_id_ready = ($urandom_range(0, 9) < 6);
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom, CTRL_W'($urandom),
          2'($urandom), 2'($urandom), $urandom_range(0, 31) == 0, acc);
    end

    // Asynchronous reset with three entries queued.
    is_id_ready = 1'b1;
    idle(DEPTH + 2);
    is_id_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer($urandom, 32'h5000 + 32'(i * 4), 2'd0, 2'd2);
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(id_is_count), 32'd0);
    chk("arst_valid", 32'(id_is_valid), 32'd0);
    chk("arst_ready", 32'(id_if_ready), 32'd1);
    chk("arst_regdest", 32'(id_is_regdest), 32'd0);
    chk("arst_imedext", id_is_imedext, 32'd0);
    chk("arst_nextpc", id_is_nextpc, 32'd0);
    chk("arst_bundle", 32'(id_is_bundle), 32'd0);
    exp_q.delete();
    #1;
    reset = 1'b1;
    idle(2);
    offer(32'h3C08ABCD, 32'h6000, 2'd0, 2'd2);
    chk("post_rst_imedext", id_is_imedext, 32'hABCD0000);
    is_id_ready = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised successor to the single-entry Decode→Issue pipeline register. It accepts fetched instructions and their control bundle through a valid/ready handshake, then extracts the destination register and the extended immediate. Results are held in a DEPTH-entry in-order queue that feeds Issue under a second valid/ready handshake. A flush clears the queue on a redirect, replacing the old single-flop stall-hold scheme.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- CTRL_W, 20: width of the opaque control bundle from Control
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_id_valid  in  1  Fetch offers an instruction
- id_if_ready  out  1  queue can accept; equals (count < DEPTH)
- if_id_instruc  in  32  instruction word
- if_id_nextpc  in  32  PC+4 of the instruction
- ctl_id_bundle  in  CTRL_W  control bits; carried unchanged
- ctl_id_selregdest  in  2  00 rt[20:16], 01 rd[15:11], 10 r31, 11 r0
- ctl_id_immmode  in  2  00 sign-extend, 01 zero-extend, 10 imm<<16, 11 zero
- flush  in  1  discard all queued and incoming entries
- id_is_valid  out  1  head entry valid
- is_id_ready  in  1  Issue consumes the head this cycle
- id_is_bundle  out  CTRL_W  head control bundle
- id_is_regdest  out  5  head destination register
- id_is_imedext  out  32  head extended immediate
- id_is_nextpc  out  32  head PC+4
- id_is_count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Field extraction is combinational on the input side. The entry {bundle, regdest, imedext, nextpc} is formed before storage.
- Enqueue when if_id_valid && id_if_ready && !flush. Dequeue when id_is_valid && is_id_ready && !flush.
- Order is strict FIFO. Read and write pointers wrap modulo DEPTH.
- Occupancy is updated as count + enq − deq. Enqueue and dequeue may occur in the same cycle, so count is unchanged.
- id_if_ready depends only on count, never on is_id_ready, so there is no combinational path from Issue to Fetch.
- When full, ready=0 and the offered instruction must be held by Fetch. A simultaneous dequeue does not raise ready until the next cycle.
- When empty, id_is_valid=0 and the head outputs read 0.
- On flush, pointers and count are zeroed at the next edge. The incoming entry and any dequeue that cycle are dropped, and flush wins over both.
- An asynchronous reset at any time returns the block to the empty state immediately. Any in-flight entry is lost.

## Timing
- Reset values:
  - id_is_valid=0, id_is_count=0.
  - All head outputs are 0.
  - id_if_ready=1.
- Latency is 1 cycle: an entry enqueued at edge N is visible at the head after edge N.
- id_is_valid and the head outputs are registered/stored state, glitch-free within a cycle.
- Throughput is 1 entry per cycle in steady state.
- Flush asserted in cycle N gives id_is_valid=0 and count=0 from edge N onward.

## Configuration
- DECODE_QUEUE_BYPASS_EN
  - Defined:
    - When the queue is empty, the incoming entry is presented combinationally on the head outputs with id_is_valid=if_id_valid, giving 0-cycle latency.
    - If is_id_ready=1 in that cycle, the entry is consumed and not written, and count stays 0.
    - Otherwise it is written normally.
  - Not defined: there is no input-to-output combinational path, and latency is always 1 cycle.

## Structure
- Package decode_pkg holds:
  - the regdest_sel_e and immmode_e enums;
  - the REG_RA=5'd31 constant;
  - an entry_w(CTRL_W) function returning CTRL_W+69.
- Sub-module decode_fifo is a generic DEPTH×WIDTH storage with pointers, count and flush. decode_queue wraps it with field extraction and the optional bypass mux.

## Test plan
- Reset mid-run with 3 entries queued → count=0, id_is_valid=0, all head outputs 0, id_if_ready=1, all immediately.
- 0x2408FFFF, selregdest=00, immmode=00 → one cycle later: regdest=8, imedext=0xFFFFFFFF, nextpc passed through.
- 0x3508FFFF with immmode=01 → imedext=0x0000FFFF. 0x3C081234 with immmode=10 → 0x12340000. 0x0C000010 with selregdest=10 → regdest=31.
- DEPTH=4, is_id_ready=0, 5 back-to-back offers:
  - ready drops after the 4th and count=4.
  - The 5th is held until is_id_ready=1.
  - The queue drains in order across the pointer wrap, and the 5th is enqueued when ready returns.
- count=3 plus flush plus simultaneous if_id_valid → count=0 and id_is_valid=0 next cycle; the incoming entry is never output.
- Empty queue, if_id_valid=1, is_id_ready=1:
  - With DECODE_QUEUE_BYPASS_EN: id_is_valid=1 in the same cycle and count stays 0.
  - Without it: id_is_valid=1 next cycle and count=1.
